// File: rtl/vga_write_bridge_if.sv
// rtl/vga_write_bridge_if.sv - CPU write port, status and framebuffer write bundle for vga_write_bridge
interface vga_write_bridge_if #(
    parameter int WORD_WIDTH = 32,
    parameter int FB_ADDR_W  = 17,
    parameter int PIXEL_W    = 8
) ();
    logic                  cpu_wr;
    logic [WORD_WIDTH-1:0] cpu_addr;
    logic [WORD_WIDTH-1:0] cpu_data;
    logic                  cpu_ready;
    logic                  stat_clr;
    logic [WORD_WIDTH-1:0] stat;
    logic                  fb_busy;
    logic                  fb_we;
    logic [FB_ADDR_W-1:0]  fb_addr;
    logic [PIXEL_W-1:0]    fb_data;

    // Environment side: CPU and VGA framebuffer
    modport master (
        output cpu_wr, cpu_addr, cpu_data, stat_clr, fb_busy,
        input  cpu_ready, stat, fb_we, fb_addr, fb_data
    );

    // Bridge side
    modport slave (
        input  cpu_wr, cpu_addr, cpu_data, stat_clr, fb_busy,
        output cpu_ready, stat, fb_we, fb_addr, fb_data
    );
endinterface

// File: rtl/vga_write_bridge.sv
// rtl/vga_write_bridge.sv - posted-write FIFO from CPU port to VGA framebuffer, with status word
// Optional macro VGA_BRIDGE_RANGE_CHECK_EN: drop and flag writes addressed at or beyond FB_SIZE.
module vga_write_bridge #(
    parameter int WORD_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int FB_ADDR_W  = 17,
    parameter int PIXEL_W    = 8,
    parameter int FB_SIZE    = 76800
) (
    input  logic              clk,
    input  logic              rst,
    vga_write_bridge_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = FB_ADDR_W + PIXEL_W;

    typedef enum logic {S_IDLE = 1'b0, S_DRAIN = 1'b1} state_t;

    logic [EW-1:0]         mem [DEPTH];
    logic [EW-1:0]         head;
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;
    logic [AW:0]           count_n;
    logic                  full;
    logic                  empty;
    logic                  accept;
    logic                  in_range;
    logic                  push;
    logic                  pop;
    logic                  overflow;
    logic                  overflow_n;
    logic                  range_err;
    logic                  range_err_n;
    logic [WORD_WIDTH-1:0] stat_q;
    logic [WORD_WIDTH-1:0] stat_n;
    logic [FB_ADDR_W-1:0]  fb_addr_q;
    logic [PIXEL_W-1:0]    fb_data_q;
    logic                  fb_we_d;
    state_t                state;
    state_t                state_n;
    logic                  unused_bits;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign accept   = bus.cpu_wr && !full;
    assign head     = mem[rd_ptr];

`ifdef VGA_BRIDGE_RANGE_CHECK_EN
    assign in_range = (bus.cpu_addr < WORD_WIDTH'(FB_SIZE));
`else
    assign in_range = 1'b1;
`endif

    // An out-of-range write is still accepted (ready is unaffected), it just never lands in the FIFO
    assign push = accept && in_range;

    assign unused_bits = ^{bus.cpu_addr[WORD_WIDTH-1:FB_ADDR_W], bus.cpu_data[WORD_WIDTH-1:PIXEL_W]};

    // Drain FSM: DRAIN means a framebuffer write was issued at the last edge
    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = S_IDLE;
        if (!empty && !bus.fb_busy) state_n = S_DRAIN;
    end

    always_comb begin
        pop     = 1'b0;
        fb_we_d = (state == S_DRAIN);
        if (!empty && !bus.fb_busy) pop = 1'b1;
    end

    always_comb begin
        count_n = count;
        case ({push, pop})
            2'b10:   count_n = count + (AW+1)'(1);
            2'b01:   count_n = count - (AW+1)'(1);
            default: count_n = count;
        endcase
    end

    // Sticky flags: a set event at the same edge beats a clear
    always_comb begin
        overflow_n  = overflow;
        range_err_n = range_err;
        if (bus.stat_clr) begin
            overflow_n  = 1'b0;
            range_err_n = 1'b0;
        end
        if (bus.cpu_wr && full)  overflow_n  = 1'b1;
        if (accept && !in_range) range_err_n = 1'b1;
    end

    always_comb begin
        stat_n        = '0;
        stat_n[0]     = (count_n != (AW+1)'(DEPTH));
        stat_n[1]     = (count_n == '0);
        stat_n[2]     = overflow_n;
        stat_n[3]     = range_err_n;
        stat_n[15:8]  = 8'(count_n);
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {bus.cpu_addr[FB_ADDR_W-1:0], bus.cpu_data[PIXEL_W-1:0]};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            range_err <= 1'b0;
            fb_addr_q <= '0;
            fb_data_q <= '0;
            stat_q    <= WORD_WIDTH'(3);
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) begin
                rd_ptr    <= rd_ptr + AW'(1);
                fb_addr_q <= head[EW-1:PIXEL_W];
                fb_data_q <= head[PIXEL_W-1:0];
            end
            count     <= count_n;
            overflow  <= overflow_n;
            range_err <= range_err_n;
            stat_q    <= stat_n;
        end
    end

    assign bus.cpu_ready = !full;
    assign bus.stat      = stat_q;
    assign bus.fb_we     = fb_we_d;
    assign bus.fb_addr   = fb_addr_q;
    assign bus.fb_data   = fb_data_q;
endmodule

// File: tb/tb_vga_write_bridge.sv
// tb/tb_vga_write_bridge.sv - directed self-checking bench for vga_write_bridge
module tb_vga_write_bridge;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   n_out;
    int   n_we;
    logic [16:0] seen [$];

    vga_write_bridge_if #(.WORD_WIDTH(32), .FB_ADDR_W(17), .PIXEL_W(8)) bus ();

    vga_write_bridge #(
        .WORD_WIDTH(32), .DEPTH(8), .FB_ADDR_W(17), .PIXEL_W(8), .FB_SIZE(76800)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.cpu_wr   = 1'b1;
        bus.cpu_addr = a;
        bus.cpu_data = d;
        tick();
        bus.cpu_wr   = 1'b0;
    endtask

    initial begin
        bus.cpu_wr   = 1'b0;
        bus.cpu_addr = '0;
        bus.cpu_data = '0;
        bus.stat_clr = 1'b0;
        bus.fb_busy  = 1'b0;
        tick();
        tick();
        chk("rst_we",    32'(bus.fb_we),     32'd0);
        chk("rst_addr",  32'(bus.fb_addr),   32'd0);
        chk("rst_data",  32'(bus.fb_data),   32'd0);
        chk("rst_stat",  bus.stat,           32'h0000_0003);
        chk("rst_ready", 32'(bus.cpu_ready), 32'd1);
        rst = 1'b1;
        tick();

        // Single write latency
        wr(32'h10, 32'h1A5);
        chk("t1_we_e",    32'(bus.fb_we), 32'd0);
        chk("t1_stat_e",  bus.stat,       32'h0000_0101);
        tick();
        chk("t1_we",      32'(bus.fb_we),   32'd1);
        chk("t1_addr",    32'(bus.fb_addr), 32'h10);
        chk("t1_data",    32'(bus.fb_data), 32'hA5);
        chk("t1_stat",    bus.stat,         32'h0000_0003);
        tick();
        chk("t1_we_off",  32'(bus.fb_we),   32'd0);

        // Fill past full while busy
        bus.fb_busy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wr(32'(i), 32'(i + 32'h20));
            if (i == 6) chk("t2_ready7", 32'(bus.cpu_ready), 32'd1);
            if (i == 7) chk("t2_ready8", 32'(bus.cpu_ready), 32'd0);
        end
        chk("t2_stat_full", bus.stat,       32'h0000_0804);
        chk("t2_no_we",     32'(bus.fb_we), 32'd0);
        bus.fb_busy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("t2_we%0d", i),   32'(bus.fb_we),   32'd1);
            chk($sformatf("t2_addr%0d", i), 32'(bus.fb_addr), 32'(i));
            chk($sformatf("t2_data%0d", i), 32'(bus.fb_data), 32'(i + 32'h20));
        end
        tick();
        chk("t2_we_end",  32'(bus.fb_we), 32'd0);
        chk("t2_stat_ov", bus.stat,       32'h0000_0007);
        bus.stat_clr = 1'b1;
        tick();
        bus.stat_clr = 1'b0;
        chk("t2_stat_clr", bus.stat, 32'h0000_0003);

        // Steady state at count 3 with pointer wrap
        bus.fb_busy = 1'b1;
        for (int k = 0; k < 3; k++) wr(32'h100 + 32'(k), 32'(k));
        bus.fb_busy = 1'b0;
        for (int k = 3; k < 23; k++) begin
            bus.cpu_wr   = 1'b1;
            bus.cpu_addr = 32'h100 + 32'(k);
            bus.cpu_data = 32'(k);
            tick();
            chk($sformatf("t3_cnt%0d", k),  {24'd0, bus.stat[15:8]}, 32'd3);
            chk($sformatf("t3_we%0d", k),   32'(bus.fb_we),   32'd1);
            chk($sformatf("t3_addr%0d", k), 32'(bus.fb_addr), 32'h100 + 32'(k - 3));
            chk($sformatf("t3_data%0d", k), 32'(bus.fb_data), 32'(k - 3));
        end
        bus.cpu_wr = 1'b0;
        for (int k = 20; k < 23; k++) begin
            tick();
            chk($sformatf("t3_tail_addr%0d", k), 32'(bus.fb_addr), 32'h100 + 32'(k));
            chk($sformatf("t3_tail_we%0d", k),   32'(bus.fb_we),   32'd1);
        end
        tick();
        chk("t3_stat_end", bus.stat, 32'h0000_0003);

        // Drain under alternating busy
        bus.fb_busy = 1'b1;
        for (int k = 0; k < 4; k++) wr(32'h200 + 32'(k), 32'(k + 32'h40));
        n_out = 0;
        for (int c = 0; c < 8; c++) begin
            bus.fb_busy = (c % 2 == 0);
            tick();
            if (c % 2 == 0) begin
                chk($sformatf("t4_stall%0d", c), 32'(bus.fb_we), 32'd0);
            end else begin
                chk($sformatf("t4_we%0d", c),   32'(bus.fb_we),   32'd1);
                chk($sformatf("t4_addr%0d", c), 32'(bus.fb_addr), 32'h200 + 32'(n_out));
                chk($sformatf("t4_data%0d", c), 32'(bus.fb_data), 32'(n_out + 32'h40));
                n_out++;
            end
        end
        bus.fb_busy = 1'b0;
        tick();
        chk("t4_stat_end", bus.stat, 32'h0000_0003);

        // Range check boundary
        seen.delete();
        bus.cpu_wr   = 1'b1;
        bus.cpu_addr = 32'd76800;
        bus.cpu_data = 32'h11;
        tick();
        if (bus.fb_we) seen.push_back(bus.fb_addr);
        bus.cpu_addr = 32'd76799;
        bus.cpu_data = 32'h22;
        tick();
        if (bus.fb_we) seen.push_back(bus.fb_addr);
        bus.cpu_wr = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (bus.fb_we) seen.push_back(bus.fb_addr);
        end
`ifdef VGA_BRIDGE_RANGE_CHECK_EN
        chk("t5_nwe", 32'(seen.size()), 32'd1);
        if (seen.size() > 0) chk("t5_addr", 32'(seen[0]), 32'd76799);
        chk("t5_stat_err", bus.stat, 32'h0000_000B);
        bus.stat_clr = 1'b1;
        tick();
        bus.stat_clr = 1'b0;
        chk("t5_stat_clr", bus.stat, 32'h0000_0003);
`else
        chk("t5_nwe", 32'(seen.size()), 32'd2);
        if (seen.size() > 1) begin
            chk("t5_addr0", 32'(seen[0]), 32'd76800 & 32'h1FFFF);
            chk("t5_addr1", 32'(seen[1]), 32'd76799);
        end
        chk("t5_stat", bus.stat, 32'h0000_0003);
`endif

        // Reset with entries queued
        bus.fb_busy = 1'b1;
        for (int k = 0; k < 5; k++) wr(32'h300 + 32'(k), 32'(k));
        chk("t6_stat_q", bus.stat, 32'h0000_0501);
        bus.fb_busy = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("t6_we",    32'(bus.fb_we), 32'd0);
        chk("t6_stat",  bus.stat,       32'h0000_0003);
        n_we = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (bus.fb_we) n_we++;
        end
        chk("t6_no_we",   32'(n_we),  32'd0);
        chk("t6_stat_end", bus.stat,  32'h0000_0003);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
